// File: rtl/relu_stream_ctrl.sv
// relu_stream_ctrl
// ----------------
// Job sequencer for the ReLU processing element. One job streams n words
// from a source SRAM through the PE input, and writes the PE output words
// to a destination SRAM. Both SRAMs are base-addressed. When the PE stops
// producing output during the drain phase, a watchdog aborts the job.
//
// Optional feature: define RELU_CTRL_PERF_EN to add the cycle_cnt output.
// cycle_cnt counts the busy cycles of the most recent job.
//
// Parameters
//   WORD_SIZE  data word width
//   ADDR_BITS  SRAM word-address width
//   TIMEOUT    consecutive idle drain cycles before abort (>= 1)
//
// Ports
//   clk, rst            clock (rising edge); asynchronous active-low reset
//   start               job request, sampled only while idle
//   n                   job length 0..2^ADDR_BITS, latched on accepted start
//   src_base, dst_base  first source / destination address, latched on start
//   busy, done, err     status: busy until done pulse, one-cycle done,
//                       sticky watchdog abort flag
//   src_addr, src_do    source SRAM port (1-cycle synchronous read)
//   pe_di_valid, pe_di  PE input (pe_di is src_do passed straight through)
//   pe_do_valid, pe_do  PE output
//   dst_wen, dst_addr,
//   dst_di              destination SRAM write port
//   cycle_cnt           [RELU_CTRL_PERF_EN only] busy-cycle counter
module relu_stream_ctrl #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 10,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS:0]   n,
  input  logic [ADDR_BITS-1:0] src_base,
  input  logic [ADDR_BITS-1:0] dst_base,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_BITS-1:0] src_addr,
  input  logic [WORD_SIZE-1:0] src_do,
  output logic                 pe_di_valid,
  output logic [WORD_SIZE-1:0] pe_di,
  input  logic                 pe_do_valid,
  input  logic [WORD_SIZE-1:0] pe_do,
  output logic                 dst_wen,
  output logic [ADDR_BITS-1:0] dst_addr,
  output logic [WORD_SIZE-1:0] dst_di
`ifdef RELU_CTRL_PERF_EN
  ,
  output logic [31:0]          cycle_cnt
`endif
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_BITS:0] CNT_ONE    = (ADDR_BITS+1)'(1);
  localparam logic [WD_W-1:0]    WD_ONE     = WD_W'(1);
  localparam logic [WD_W-1:0]    WD_LIMIT   = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS:0]   n_q, n_d;
  logic [ADDR_BITS-1:0] src_base_q, src_base_d;
  logic [ADDR_BITS-1:0] dst_base_q, dst_base_d;
  logic [ADDR_BITS:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_BITS:0]   wr_cnt_q, wr_cnt_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 abort_q, abort_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [ADDR_BITS-1:0] src_addr_q, src_addr_d;
  logic                 pe_di_valid_q, pe_di_valid_d;
  logic                 dst_wen_q, dst_wen_d;
  logic [ADDR_BITS-1:0] dst_addr_q, dst_addr_d;
  logic [WORD_SIZE-1:0] dst_di_q, dst_di_d;

  logic                 wr_accept;
  logic [ADDR_BITS:0]   rd_next;
  logic [WD_W-1:0]      wd_inc;

  // The SRAM read data is already registered, so the PE sees it directly.
  assign pe_di = src_do;

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    src_base_d    = src_base_q;
    dst_base_d    = dst_base_q;
    rd_cnt_d      = rd_cnt_q;
    wr_cnt_d      = wr_cnt_q;
    wd_d          = wd_q;
    abort_d       = abort_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = err_q;
    src_addr_d    = src_addr_q;
    dst_wen_d     = 1'b0;
    dst_addr_d    = dst_addr_q;
    dst_di_d      = dst_di_q;
    // The read data for an issued address arrives one cycle after the
    // address, so the valid signal is the ISSUE state delayed by one cycle.
    pe_di_valid_d = (state_q == ISSUE);
    rd_next       = rd_cnt_q + CNT_ONE;
    wd_inc        = wd_q + WD_ONE;

    // Write path. Output words that arrive outside an active job, or after
    // all n words are written, are dropped.
    wr_accept = ((state_q == ISSUE) || (state_q == DRAIN)) &&
                pe_do_valid && (wr_cnt_q != n_q);
    if (wr_accept) begin
      dst_wen_d  = 1'b1;
      dst_addr_d = dst_base_q + wr_cnt_q[ADDR_BITS-1:0];
      dst_di_d   = pe_do;
      wr_cnt_d   = wr_cnt_q + CNT_ONE;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          n_d        = n;
          src_base_d = src_base;
          dst_base_d = dst_base;
          rd_cnt_d   = '0;
          wr_cnt_d   = '0;
          wd_d       = '0;
          abort_d    = 1'b0;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          if (n != '0) begin
            state_d    = ISSUE;
            src_addr_d = src_base;
          end else begin
            state_d = FIN;
          end
        end
      end

      ISSUE: begin
        if (rd_cnt_q == n_q - CNT_ONE) begin
          state_d = DRAIN;
        end else begin
          rd_cnt_d   = rd_next;
          src_addr_d = src_base_q + rd_next[ADDR_BITS-1:0];
        end
      end

      DRAIN: begin
        wd_d = pe_do_valid ? '0 : wd_inc;
        // Count the write happening this cycle, so FIN follows the last
        // write without an extra cycle.
        if (wr_cnt_d == n_q) begin
          state_d = FIN;
        end else if (!pe_do_valid && (wd_inc == WD_LIMIT)) begin
          state_d = FIN;
          abort_d = 1'b1;
        end
      end

      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        // The abort flag becomes visible together with done.
        err_d   = err_q | abort_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      n_q           <= '0;
      src_base_q    <= '0;
      dst_base_q    <= '0;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      wd_q          <= '0;
      abort_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      src_addr_q    <= '0;
      pe_di_valid_q <= 1'b0;
      dst_wen_q     <= 1'b0;
      dst_addr_q    <= '0;
      dst_di_q      <= '0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      src_base_q    <= src_base_d;
      dst_base_q    <= dst_base_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      wd_q          <= wd_d;
      abort_q       <= abort_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      src_addr_q    <= src_addr_d;
      pe_di_valid_q <= pe_di_valid_d;
      dst_wen_q     <= dst_wen_d;
      dst_addr_q    <= dst_addr_d;
      dst_di_q      <= dst_di_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign src_addr    = src_addr_q;
  assign pe_di_valid = pe_di_valid_q;
  assign dst_wen     = dst_wen_q;
  assign dst_addr    = dst_addr_q;
  assign dst_di      = dst_di_q;

`ifdef RELU_CTRL_PERF_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  // Counts the cycles where busy is high. The count saturates and holds
  // its value after done, until the next job starts.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if ((state_q == IDLE) && start) begin
      cycle_cnt_d = '0;
    end else if (busy_q && (cycle_cnt_q != '1)) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// Testbench for relu_stream_ctrl. The bench contains a source SRAM model,
// a ReLU PE model with a configurable latency, and a scoreboard.
// The scoreboard queues hold the expected PE input words and the expected
// destination writes. A monitor compares these against the DUT outputs.
`timescale 1ns/1ps
module tb_relu_stream_ctrl;
  localparam int WS    = 16;
  localparam int AB    = 10;
  localparam int TO    = 255;
  localparam int DEPTH = 1 << AB;
  localparam int LMAX  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AB:0]   n = '0;
  logic [AB-1:0] src_base = '0;
  logic [AB-1:0] dst_base = '0;
  logic          busy, done, err;
  logic [AB-1:0] src_addr;
  logic [WS-1:0] src_do;
  logic          pe_di_valid;
  logic [WS-1:0] pe_di;
  logic          pe_do_valid;
  logic [WS-1:0] pe_do;
  logic          dst_wen;
  logic [AB-1:0] dst_addr;
  logic [WS-1:0] dst_di;
`ifdef RELU_CTRL_PERF_EN
  logic [31:0]   cycle_cnt;
`endif

  always #5 clk = ~clk;

  relu_stream_ctrl #(.WORD_SIZE(WS), .ADDR_BITS(AB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n),
    .src_base(src_base), .dst_base(dst_base),
    .busy(busy), .done(done), .err(err),
    .src_addr(src_addr), .src_do(src_do),
    .pe_di_valid(pe_di_valid), .pe_di(pe_di),
    .pe_do_valid(pe_do_valid), .pe_do(pe_do),
    .dst_wen(dst_wen), .dst_addr(dst_addr), .dst_di(dst_di)
`ifdef RELU_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int rd_seen = 0;
  int done_seen = 0;

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [WS-1:0] relu(logic [WS-1:0] x);
    return x[WS-1] ? '0 : x;
  endfunction

  // Source SRAM model with a 1-cycle synchronous read.
  logic [WS-1:0] mem [DEPTH];
  always @(posedge clk) src_do <= mem[src_addr];

  // PE model: ReLU with a latency of `lat` cycles. `kill` suppresses all
  // PE output. `extra_en` adds one extra valid word after the last real word.
  int lat = 1;
  bit kill = 1'b0;
  bit extra_en = 1'b0;
  logic          vpipe [LMAX+1];
  logic [WS-1:0] dpipe [LMAX+1];
  initial for (int k = 0; k <= LMAX; k++) begin vpipe[k] = 1'b0; dpipe[k] = '0; end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    vpipe[0] <= pe_di_valid;
    dpipe[0] <= relu(pe_di);
    for (int k = 1; k <= LMAX; k++) begin
      vpipe[k] <= vpipe[k-1];
      dpipe[k] <= dpipe[k-1];
    end
  end
  always_comb begin
    pe_do_valid = !kill && (vpipe[lat-1] || (extra_en && vpipe[lat]));
    pe_do       = vpipe[lat-1] ? dpipe[lat-1] : (dpipe[lat] ^ 16'h0101);
  end

  // Scoreboard
  logic [WS-1:0]    exp_rd [$];
  logic [AB+WS-1:0] exp_wr [$];
  logic [WS-1:0]    e_rd;
  logic [AB+WS-1:0] e_wr;

  always @(negedge clk) begin
    if (rst) begin
      if (pe_di_valid) begin
        rd_seen++;
        check("rd_expected", exp_rd.size() > 0, 1);
        if (exp_rd.size() > 0) begin
          e_rd = exp_rd.pop_front();
          check("rd_data", pe_di, e_rd);
        end
      end
      if (dst_wen) begin
        check("wr_expected", exp_wr.size() > 0, 1);
        if (exp_wr.size() > 0) begin
          e_wr = exp_wr.pop_front();
          $display("write addr=%0d data=%0d expected addr=%0d data=%0d",
                   dst_addr, dst_di, e_wr[AB+WS-1:WS], e_wr[WS-1:0]);
          check("wr_addr_data", {dst_addr, dst_di}, e_wr);
        end
      end
      if (done) done_seen++;
    end
  end

  // Reference model for one job. For every source word (src_base+i) mod
  // 2^AB, the PE input must see that word, and the destination must receive
  // its ReLU at (dst_base+i) mod 2^AB. The expected done latency is computed
  // from the job length, the PE latency, and the watchdog limit.
  task automatic run_job(int nn, int sb, int db, int l, bit k, bit hold, bit ex);
    int t0;
    int exp_lat;
    bit got;
    lat = l;
    kill = k;
    extra_en = ex;
    for (int i = 0; i < nn; i++) begin
      exp_rd.push_back(mem[(sb + i) % DEPTH]);
      if (!k) exp_wr.push_back({AB'((db + i) % DEPTH), relu(mem[(sb + i) % DEPTH])});
    end
    rd_seen = 0;
    done_seen = 0;
    @(negedge clk);
    start = 1'b1;
    n = (AB+1)'(nn);
    src_base = AB'(sb);
    dst_base = AB'(db);
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    if (!hold) start = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_cleared", err, 0);
    if (nn != 0) check("src_addr_first", src_addr, sb);
    exp_lat = (nn == 0) ? 1 : (k ? nn + TO + 1 : nn + l + 2);
    got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", got, 1);
    if (got) begin
      check("done_latency", cyc - t0, exp_lat);
      check("busy_at_done", busy, 0);
      check("err_at_done", err, k);
    end
    repeat (LMAX + 2) @(negedge clk);
    check("done_count", done_seen, 1);
    check("read_count", rd_seen, nn);
    check("writes_pending", exp_wr.size(), 0);
    check("reads_pending", exp_rd.size(), 0);
    check("err_sticky", err, k);
    $display("job n=%0d src=%0d dst=%0d lat=%0d kill=%0d done after %0d cycles",
             nn, sb, db, l, k, cyc - t0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = WS'($urandom);
    mem[0] = 16'd5;
    mem[1] = 16'hFFFD;
    mem[2] = 16'd0;
    mem[3] = 16'd7;

    #1;
    check("reset_outputs", {busy, done, err, pe_di_valid, dst_wen, src_addr, dst_addr, dst_di}, 0);
`ifdef RELU_CTRL_PERF_EN
    check("reset_cycle_cnt", cycle_cnt, 0);
`endif
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Test-plan job: writes {5,0,0,7} to 8..11, done 7 cycles after start.
    run_job(4, 0, 8, 1, 1'b0, 1'b0, 1'b0);
`ifdef RELU_CTRL_PERF_EN
    check("cycle_cnt_n4", cycle_cnt, 7);
`endif
    // Empty job
    run_job(0, 5, 6, 1, 1'b0, 1'b0, 1'b0);
    // Address wrap on both sides
    run_job(3, 1022, 1023, 2, 1'b0, 1'b0, 1'b0);
    // Watchdog abort; the following job checks that err is cleared
    run_job(2, 100, 200, 1, 1'b1, 1'b0, 1'b0);
    // start held through the job plus a stray valid after the last write
    run_job(5, 300, 400, 3, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of ISSUE
    lat = 1; kill = 1'b0; extra_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_rd.push_back(mem[(50 + i) % DEPTH]);
      exp_wr.push_back({AB'((60 + i) % DEPTH), relu(mem[(50 + i) % DEPTH])});
    end
    @(negedge clk);
    start = 1'b1; n = 11'd8; src_base = 10'd50; dst_base = 10'd60;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_reset_outputs", {busy, done, err, pe_di_valid, dst_wen, src_addr, dst_addr, dst_di}, 0);
    exp_rd.delete();
    exp_wr.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (LMAX + 2) @(negedge clk);
    run_job(4, 0, 8, 1, 1'b0, 1'b0, 1'b0);
`ifdef RELU_CTRL_PERF_EN
    check("cycle_cnt_after_reset", cycle_cnt, 7);
`endif

    // Random jobs; the last one covers the full 2^AB length.
    for (int j = 0; j < 6; j++) begin
      run_job((j == 5) ? DEPTH : int'($urandom_range(1, 40)),
              int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
              int'($urandom_range(1, 4)), 1'b0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
